// File: rtl/fifo_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fifo_param                                                 |
// | Description : Parametrised single-clock FIFO with occupancy count,       |
// |               programmable almost-full/almost-empty thresholds and       |
// |               one-cycle overflow/underflow error pulses.                 |
// |               Define FIFO_PARAM_FWFT_EN for first-word-fall-through      |
// |               read mode; otherwise reads are registered (1-cycle).       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module fifo_param #(
   parameter int DATA_W    = 32,
   parameter int DEPTH     = 16,
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wen,
   input  logic [DATA_W-1:0]          wdata,
   input  logic                       ren,
   output logic [DATA_W-1:0]          rdata,
   output logic                       rvalid,
   output logic                       full,
   output logic                       empty,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int c_AW = $clog2(DEPTH);
   localparam int c_CW = c_AW + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [c_AW-1:0]   wr_ptr_q;
   logic [c_AW-1:0]   rd_ptr_q;
   logic [c_CW-1:0]   count_q;
   logic [c_CW-1:0]   count_d;
   logic              full_q;
   logic              empty_q;
   logic              afull_q;
   logic              aempty_q;
   logic              ovf_q;
   logic              udf_q;
   logic              w_wr_acc;
   logic              w_rd_acc;

   // Requests are qualified by the registered flags and ignored during reset
   assign w_wr_acc = !rst && wen && !full_q;
   assign w_rd_acc = !rst && ren && !empty_q;

   // Next occupancy: simultaneous accepted read and write cancel out
   always_comb begin
      count_d = count_q;
      if (rst) begin
         count_d = '0;
      end else if (w_wr_acc && !w_rd_acc) begin
         count_d = count_q + 1'b1;
      end else if (w_rd_acc && !w_wr_acc) begin
         count_d = count_q - 1'b1;
      end
   end

   // Storage array is deliberately left out of reset
   always_ff @(posedge clk) begin
      if (w_wr_acc) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

   // Pointers, count, flags (decoded from next count) and error pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         afull_q  <= 1'b0;
         aempty_q <= 1'b1;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         if (w_wr_acc) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (w_rd_acc) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         count_q  <= count_d;
         full_q   <= (count_d == c_CW'(DEPTH));
         empty_q  <= (count_d == '0);
         afull_q  <= (count_d >= c_CW'(AF_THRESH));
         aempty_q <= (count_d <= c_CW'(AE_THRESH));
         ovf_q    <= wen && full_q;
         udf_q    <= ren && empty_q;
      end
   end

`ifdef FIFO_PARAM_FWFT_EN
   // Head entry falls through; forced to zero while nothing is stored
   assign rdata  = empty_q ? '0 : mem_q[rd_ptr_q];
   assign rvalid = !empty_q;
`else
   logic [DATA_W-1:0] rdata_q;
   logic              rvalid_q;

   // Registered read: capture head word, pulse valid for one cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         rvalid_q <= w_rd_acc;
         if (w_rd_acc) begin
            rdata_q <= mem_q[rd_ptr_q];
         end
      end
   end

   assign rdata  = rdata_q;
   assign rvalid = rvalid_q;
`endif

   assign full         = full_q;
   assign empty        = empty_q;
   assign almost_full  = afull_q;
   assign almost_empty = aempty_q;
   assign count        = count_q;
   assign overflow     = ovf_q;
   assign underflow    = udf_q;

endmodule
`default_nettype wire
